slot_bank: RTL and testbench

Parametrised credit bank for the slot-machine game: accumulates a player bet from denomination buttons, debits it on a spin request, accepts a vector of `NUM_REELS` reel symbols from the random-number source, evaluates the match, and credits a saturating payout. It generalises the fixed 4-reel, fixed-width bank with reel count, balance width, symbol width, bet cap and jackpot multiplier as parameters, and adds a spin/result handshake, bet validation and a payout report. Its `balance` output feeds the VGA score display directly.

---
 rtl/slot_bank.sv | 147 ++++++++++++++
 tb/tb_slot_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_bank.sv
// rtl/slot_bank.sv - credit bank for the slot machine: bet entry, spin debit, reel match and saturating payout
module slot_bank #(
  parameter int BAL_W      = 27,
  parameter int NUM_REELS  = 4,
  parameter int SYM_W      = 5,
  parameter int INIT_BAL   = 1000,
  parameter int MAX_BET    = 500,
  parameter int JACKPOT_SH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       b1,
  input  logic                       b10,
  input  logic                       b50,
  input  logic                       b100,
  input  logic                       spin,
  input  logic [NUM_REELS*SYM_W-1:0] reels,
  input  logic                       reels_valid,
  output logic [BAL_W-1:0]           balance,
  output logic [BAL_W-1:0]           bet,
  output logic [BAL_W-1:0]           last_payout,
  output logic                       busy,
  output logic                       win,
  output logic                       bet_reject
);

  localparam int W1  = BAL_W + 1;
  localparam int PW  = BAL_W + JACKPOT_SH;
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_EVAL, S_PAY} state_t;

  state_t                       r_state;
  logic [4:0]                   r_btn_q;
  logic [BAL_W-1:0]             r_balance;
  logic [BAL_W-1:0]             r_bet;
  logic [BAL_W-1:0]             r_last_payout;
  logic                         r_busy;
  logic                         r_win;
  logic                         r_bet_reject;
  logic [NUM_REELS*SYM_W-1:0]   r_reels;
  logic [PW-1:0]                r_payout;

  logic [4:0]       w_btn;
  logic [4:0]       w_rise;
  logic [7:0]       w_inc;
  logic [W1-1:0]    w_new_bet;
  logic             w_bet_ok;
  logic [7:0]       w_matches;
  logic [PW-1:0]    w_payout;
  logic [PW1-1:0]   w_sum;
  logic [BAL_W-1:0] w_max;

  assign w_btn  = {spin, b100, b50, b10, b1};
  assign w_rise = w_btn & ~r_btn_q;
  assign w_max  = {BAL_W{1'b1}};

  assign w_inc = (w_rise[0] ? 8'd1  : 8'd0) + (w_rise[1] ? 8'd10  : 8'd0)
               + (w_rise[2] ? 8'd50 : 8'd0) + (w_rise[3] ? 8'd100 : 8'd0);

  assign w_new_bet = {1'b0, r_bet} + W1'(w_inc);
  assign w_bet_ok  = (w_inc != 8'd0) && (w_new_bet <= W1'(MAX_BET))
                   && (w_new_bet <= {1'b0, r_balance});

  // Count of reels agreeing with reel 0 (reel 0 always counts itself)
  always_comb begin
    w_matches = 8'd0;
    for (int k = 0; k < NUM_REELS; k++) begin
      if (r_reels[k*SYM_W +: SYM_W] == r_reels[0 +: SYM_W]) begin
        w_matches = w_matches + 8'd1;
      end
    end
  end

  always_comb begin
    w_payout = '0;
    if (w_matches == 8'(NUM_REELS)) begin
      w_payout = PW'(r_bet) << JACKPOT_SH;
    end else if (w_matches == 8'(NUM_REELS - 1)) begin
      w_payout = PW'(r_bet) << 1;
    end
  end

  assign w_sum = PW1'(r_balance) + PW1'(r_payout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_btn_q       <= '0;
      r_balance     <= BAL_W'(INIT_BAL);
      r_bet         <= '0;
      r_last_payout <= '0;
      r_busy        <= 1'b0;
      r_win         <= 1'b0;
      r_bet_reject  <= 1'b0;
      r_reels       <= '0;
      r_payout      <= '0;
    end else begin
      r_btn_q      <= w_btn;
      r_win        <= 1'b0;
      r_bet_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A spin takes priority; any simultaneous bet increment is dropped
          if (w_rise[4] && (r_bet != '0)) begin
            r_balance <= r_balance - r_bet;
            r_busy    <= 1'b1;
            r_state   <= S_SPIN;
          end else if (w_inc != 8'd0) begin
            if (w_bet_ok) begin
              r_bet <= w_new_bet[BAL_W-1:0];
            end else begin
              r_bet_reject <= 1'b1;
            end
          end
        end
        S_SPIN: begin
          if (reels_valid) begin
            r_reels <= reels;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_payout <= w_payout;
          r_state  <= S_PAY;
        end
        S_PAY: begin
          r_balance     <= (w_sum > PW1'(w_max)) ? w_max : w_sum[BAL_W-1:0];
          r_last_payout <= (r_payout > PW'(w_max)) ? w_max : r_payout[BAL_W-1:0];
          r_win         <= (r_payout != '0);
          r_bet         <= '0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign balance     = r_balance;
  assign bet         = r_bet;
  assign last_payout = r_last_payout;
  assign busy        = r_busy;
  assign win         = r_win;
  assign bet_reject  = r_bet_reject;

endmodule

// File: tb/tb_slot_bank.sv
// tb/tb_slot_bank.sv - scoreboard bench for slot_bank: default instance plus a 12-bit saturating instance
module tb_slot_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bb;
  logic        sp;
  logic        rv;
  logic [19:0] reels;

  logic [26:0] bal0, bet0, last0;
  logic        busy0, win0, rej0;
  logic [11:0] bal1, bet1, last1;
  logic        busy1, win1, rej1;

  always #5 clk = ~clk;

  slot_bank dut0 (
    .clk(clk), .rst(rst), .b1(bb[0]), .b10(bb[1]), .b50(bb[2]), .b100(bb[3]),
    .spin(sp), .reels(reels), .reels_valid(rv),
    .balance(bal0), .bet(bet0), .last_payout(last0),
    .busy(busy0), .win(win0), .bet_reject(rej0)
  );

  slot_bank #(.BAL_W(12), .INIT_BAL(4000)) dut1 (
    .clk(clk), .rst(rst), .b1(bb[0]), .b10(bb[1]), .b50(bb[2]), .b100(bb[3]),
    .spin(sp), .reels(reels), .reels_valid(rv),
    .balance(bal1), .bet(bet1), .last_payout(last1),
    .busy(busy1), .win(win1), .bet_reject(rej1)
  );

  typedef struct {
    longint bal;
    longint bet;
    longint last;
    bit     busy;
    bit     win;
    bit     rej;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game rules in plain arithmetic, one update per clock
  longint      m_bal[2], m_bet[2], m_last[2];
  int          m_ph[2];
  logic [19:0] m_reels[2];
  logic [4:0]  m_prev[2];
  longint      maxv[2];
  longint      initv[2];

  initial begin
    maxv[0] = (longint'(1) << 27) - 1;  initv[0] = 1000;
    maxv[1] = 4095;                     initv[1] = 4000;
    for (int d = 0; d < 2; d++) begin
      m_bal[d] = initv[d]; m_bet[d] = 0; m_last[d] = 0; m_ph[d] = 0;
      m_reels[d] = '0; m_prev[d] = '0;
    end
  end

  task automatic step(input int d);
    exp_t        e;
    logic [4:0]  btn, rise;
    longint      inc, p;
    int          m;
    btn   = {sp, bb};
    rise  = btn & ~m_prev[d];
    e.win = 0;
    e.rej = 0;
    if (rst) begin
      m_bal[d] = initv[d]; m_bet[d] = 0; m_last[d] = 0; m_ph[d] = 0; m_prev[d] = '0;
    end else begin
      m_prev[d] = btn;
      inc = (rise[0] ? 1 : 0) + (rise[1] ? 10 : 0) + (rise[2] ? 50 : 0) + (rise[3] ? 100 : 0);
      if (m_ph[d] == 0) begin
        if (rise[4] && m_bet[d] != 0) begin
          m_bal[d] = m_bal[d] - m_bet[d];
          m_ph[d]  = 1;
        end else if (inc != 0) begin
          if (m_bet[d] + inc <= 500 && m_bet[d] + inc <= m_bal[d]) m_bet[d] = m_bet[d] + inc;
          else e.rej = 1;
        end
      end else if (m_ph[d] == 1) begin
        if (rv) begin
          m_reels[d] = reels;
          m_ph[d]    = 2;
        end
      end else if (m_ph[d] == 2) begin
        m_ph[d] = 3;
      end else begin
        m = 0;
        for (int k = 0; k < 4; k++)
          if (((m_reels[d] >> (5 * k)) & 20'h1f) == (m_reels[d] & 20'h1f)) m++;
        p = (m == 4) ? m_bet[d] * 16 : (m == 3) ? m_bet[d] * 2 : 0;
        m_bal[d]  = (m_bal[d] + p > maxv[d]) ? maxv[d] : m_bal[d] + p;
        m_last[d] = (p > maxv[d]) ? maxv[d] : p;
        e.win     = (p != 0);
        m_bet[d]  = 0;
        m_ph[d]   = 0;
      end
    end
    e.bal  = m_bal[d];
    e.bet  = m_bet[d];
    e.last = m_last[d];
    e.busy = (m_ph[d] != 0);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  task automatic chk(input int d, input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, d, $time, act, req);
    end
  endtask

  // Monitor: every clock the DUTs present a registered output set
  always @(negedge clk) begin
    if (q0.size() == 0) chk(0, "scoreboard_empty", 0, 1);
    else begin
      mon_e = q0.pop_front();
      chk(0, "balance", longint'(bal0), mon_e.bal);
      chk(0, "bet", longint'(bet0), mon_e.bet);
      chk(0, "last_payout", longint'(last0), mon_e.last);
      chk(0, "busy", longint'(busy0), longint'(mon_e.busy));
      chk(0, "win", longint'(win0), longint'(mon_e.win));
      chk(0, "bet_reject", longint'(rej0), longint'(mon_e.rej));
    end
    if (q1.size() == 0) chk(1, "scoreboard_empty", 0, 1);
    else begin
      mon_e = q1.pop_front();
      chk(1, "balance", longint'(bal1), mon_e.bal);
      chk(1, "bet", longint'(bet1), mon_e.bet);
      chk(1, "last_payout", longint'(last1), mon_e.last);
      chk(1, "busy", longint'(busy1), longint'(mon_e.busy));
      chk(1, "win", longint'(win1), longint'(mon_e.win));
      chk(1, "bet_reject", longint'(rej1), longint'(mon_e.rej));
    end
  end

  function automatic logic [19:0] pk(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic cyc(input logic [3:0] b, input logic s, input logic v, input logic [19:0] r);
    bb = b; sp = s; rv = v; reels = r;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_spin(input logic [19:0] r);
    cyc(4'b0, 1'b1, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b1, r);
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; bb = '0; sp = 1'b0; rv = 1'b0; reels = '0;
    @(negedge clk);
    chk(0, "reset_balance", longint'(bal0), 1000);
    cyc(4'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc(4'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 3; i++) press(4'b0010);
    chk(0, "tp_bet30", longint'(bet0), 30);
    cyc(4'b0, 1'b1, 1'b0, '0);
    chk(0, "tp_debit", longint'(bal0), 970);
    chk(0, "tp_busy", longint'(busy0), 1);
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b1, pk(5, 5, 5, 5));
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    chk(0, "tp_jackpot_bal", longint'(bal0), 1450);
    chk(0, "tp_jackpot_pay", longint'(last0), 480);
    chk(1, "tp_sat_first", longint'(bal1), 4095);

    press(4'b0010);
    do_spin(pk(4, 5, 5, 5));
    chk(0, "tp_odd_reel0", longint'(bal0), 1440);
    press(4'b0010);
    do_spin(pk(5, 4, 5, 5));
    chk(0, "tp_three_match", longint'(bal0), 1450);

    for (int i = 0; i < 4; i++) press(4'b1000);
    press(4'b0100);
    press(4'b1001);
    chk(0, "tp_reject_keep", longint'(bet0), 450);
    press(4'b0100);
    chk(0, "tp_bet_cap", longint'(bet0), 500);
    press(4'b0001);
    do_spin(pk(1, 2, 3, 4));

    press(4'b0010);
    cyc(4'b1000, 1'b1, 1'b0, '0);
    cyc(4'b1000, 1'b0, 1'b0, '0);
    cyc(4'b1000, 1'b0, 1'b1, pk(7, 7, 7, 1));
    for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b0, 1'b0, '0);
    chk(0, "tp_held_no_inc", longint'(bet0), 0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b1, 1'b0, '0);
    chk(0, "tp_zero_spin", longint'(busy0), 0);
    cyc(4'b0, 1'b0, 1'b0, '0);

    press(4'b0010);
    cyc(4'b0, 1'b1, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cyc(4'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    chk(0, "tp_rst_spin_bal", longint'(bal0), 1000);
    chk(0, "tp_rst_spin_busy", longint'(busy0), 0);

    press(4'b1000);
    do_spin(pk(1, 1, 1, 1));
    chk(1, "tp_saturate", longint'(bal1), 4095);
    for (int i = 0; i < 5; i++) press(4'b1000);
    do_spin(pk(2, 2, 2, 2));
    chk(1, "tp_payout_clamp", longint'(last1), 4095);

    for (int n = 0; n < 4000; n++) begin
      logic [3:0]  nb;
      logic        ns;
      nb = bb;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) nb[k] = ~nb[k];
      ns  = ($urandom_range(0, 3) == 0) ? ~sp : sp;
      rst = ($urandom_range(0, 999) == 0);
      cyc(nb, ns, ($urandom_range(0, 3) == 0),
          pk(5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
             5'($urandom_range(0, 2)), 5'($urandom_range(0, 2))));
    end
    rst = 1'b0;
    cyc(4'b0, 1'b0, 1'b0, '0);
    cyc(4'b0, 1'b0, 1'b0, '0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
